// File: rtl/keypad_debouncer_if.sv
// rtl/keypad_debouncer_if.sv - raw switch lines in, conditioned key/button levels out
interface keypad_debouncer_if;
  logic [9:0] keypad_raw;
  logic       startn_raw;
  logic       stopn_raw;
  logic       clearn_raw;
  logic [9:0] keypad;
  logic [3:0] key_code;
  logic       key_strobe;
  logic       startn;
  logic       stopn;
  logic       clearn;

  modport master (
    output keypad_raw, startn_raw, stopn_raw, clearn_raw,
    input  keypad, key_code, key_strobe, startn, stopn, clearn
  );

  modport slave (
    input  keypad_raw, startn_raw, stopn_raw, clearn_raw,
    output keypad, key_code, key_strobe, startn, stopn, clearn
  );
endinterface

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - synchronise and debounce front-panel keys/buttons, single-key lockout FSM
module keypad_debouncer #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  keypad_debouncer_if.slave  io
);
  // Packed order {clearn, stopn, startn, keys}; buttons idle high, keys idle low.
  localparam logic [12:0]      IDLE_VAL = {3'b111, 10'b0};
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LOCKOUT} state_t;

  logic [12:0]      sync1_q, sync2_q;
  logic [9:0]       ks2;
  logic [2:0]       bs2;
  logic [9:0]       kprev_q, kacc_q, kacc_d;
  logic [CNT_W-1:0] kcnt_q, kcnt_d;
  logic [2:0]       bprev_q, bacc_q, bacc_d;
  logic [CNT_W-1:0] bcnt_q [3];
  logic [CNT_W-1:0] bcnt_d [3];
  state_t           state_q, state_d;
  logic [9:0]       keypad_q, keypad_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             strobe_q, strobe_d;
  logic [3:0]       kidx;
  logic             kv_one;

  assign ks2 = sync2_q[9:0];
  assign bs2 = sync2_q[12:10];

  always_comb begin
    kcnt_d = kcnt_q;
    kacc_d = kacc_q;
    if (ks2 != kprev_q) begin
      kcnt_d = '0;
    end else if (ks2 == kacc_q) begin
      kcnt_d = '0;
    end else if (kcnt_q == LAST) begin
      kacc_d = ks2;
      kcnt_d = '0;
    end else begin
      kcnt_d = kcnt_q + ONE;
    end
  end

  always_comb begin
    bacc_d = bacc_q;
    for (int i = 0; i < 3; i++) begin
      bcnt_d[i] = bcnt_q[i];
      if (bs2[i] != bprev_q[i]) begin
        bcnt_d[i] = '0;
      end else if (bs2[i] == bacc_q[i]) begin
        bcnt_d[i] = '0;
      end else if (bcnt_q[i] == LAST) begin
        bacc_d[i] = bs2[i];
        bcnt_d[i] = '0;
      end else begin
        bcnt_d[i] = bcnt_q[i] + ONE;
      end
    end
  end

  always_comb begin
    kidx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (kacc_q[i]) kidx = 4'(i);
    end
    kv_one = (kacc_q != 10'd0) && ((kacc_q & (kacc_q - 10'd1)) == 10'd0);
  end

  // Lockout: any multi-key or changed-key episode must fully release before a new press counts.
  always_comb begin
    state_d    = state_q;
    keypad_d   = keypad_q;
    key_code_d = key_code_q;
    strobe_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kacc_q != 10'd0) begin
          if (kv_one) begin
            state_d    = S_PRESSED;
            keypad_d   = kacc_q;
            key_code_d = kidx;
            strobe_d   = 1'b1;
          end else begin
            state_d  = S_LOCKOUT;
            keypad_d = 10'd0;
          end
        end
      end
      S_PRESSED: begin
        if (kacc_q == 10'd0) begin
          state_d  = S_IDLE;
          keypad_d = 10'd0;
        end else if (kacc_q != keypad_q) begin
          state_d  = S_LOCKOUT;
          keypad_d = 10'd0;
        end
      end
      S_LOCKOUT: begin
        keypad_d = 10'd0;
        if (kacc_q == 10'd0) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        keypad_d = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= IDLE_VAL;
      sync2_q    <= IDLE_VAL;
      kprev_q    <= 10'd0;
      kacc_q     <= 10'd0;
      kcnt_q     <= '0;
      bprev_q    <= 3'b111;
      bacc_q     <= 3'b111;
      for (int i = 0; i < 3; i++) bcnt_q[i] <= '0;
      state_q    <= S_IDLE;
      keypad_q   <= 10'd0;
      key_code_q <= 4'd0;
      strobe_q   <= 1'b0;
    end else begin
      sync1_q    <= {io.clearn_raw, io.stopn_raw, io.startn_raw, io.keypad_raw};
      sync2_q    <= sync1_q;
      kprev_q    <= ks2;
      kacc_q     <= kacc_d;
      kcnt_q     <= kcnt_d;
      bprev_q    <= bs2;
      bacc_q     <= bacc_d;
      for (int i = 0; i < 3; i++) bcnt_q[i] <= bcnt_d[i];
      state_q    <= state_d;
      keypad_q   <= keypad_d;
      key_code_q <= key_code_d;
      strobe_q   <= strobe_d;
    end
  end

  assign io.keypad     = keypad_q;
  assign io.key_code   = key_code_q;
  assign io.key_strobe = strobe_q;
  assign io.startn     = bacc_q[0];
  assign io.stopn      = bacc_q[1];
  assign io.clearn     = bacc_q[2];
endmodule

// File: tb/tb_keypad_debouncer.sv
// tb/tb_keypad_debouncer.sv - directed plan plus random traffic against a sliding-window reference
module tb_keypad_debouncer;
  localparam int N = 4;
  localparam logic [12:0] IDLE_VAL = {3'b111, 10'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_debouncer_if io ();

  keypad_debouncer #(.STABLE_CYCLES(N), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int total = 0;
  int bad   = 0;

  // reference: raw sample history, accepted levels, selection state
  logic [12:0] hist[$];
  logic [12:0] m_acc;
  int          m_mode;
  logic [9:0]  m_keypad;
  logic [3:0]  m_code;
  logic        m_strobe;

  int         cyc = 0;
  int         n_strobe, strobe_cyc;
  logic [3:0] strobe_code;
  logic       last_startn;
  int         fall_cyc, rise_cyc, other_low;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [12:0] raw);
    logic [12:0] mask;
    logic [9:0]  kv;
    bit          same;
    if (r) begin
      hist.delete();
      for (int i = 0; i < N + 3; i++) hist.push_back(IDLE_VAL);
      m_acc = IDLE_VAL; m_mode = 0; m_keypad = '0; m_code = '0; m_strobe = 1'b0;
      return;
    end
    hist.push_back(raw);
    void'(hist.pop_front());
    // selection rules see the accepted key word from before this edge
    kv = m_acc[9:0];
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      if (kv != 0) begin
        if ($countones(kv) == 1) begin
          m_mode = 1; m_keypad = kv; m_strobe = 1'b1;
          for (int i = 0; i < 10; i++) if (kv[i]) m_code = 4'(i);
        end else begin
          m_mode = 2; m_keypad = '0;
        end
      end
    end else if (m_mode == 1) begin
      if (kv == 0) begin m_mode = 0; m_keypad = '0; end
      else if (kv != m_keypad) begin m_mode = 2; m_keypad = '0; end
    end else if (kv == 0) begin
      m_mode = 0;
    end
    // a channel accepts once N+1 consecutive samples, two edges old, agree
    for (int ch = 0; ch < 4; ch++) begin
      mask = (ch == 0) ? 13'h03FF : (13'h0001 << (9 + ch));
      same = 1'b1;
      for (int j = 1; j <= N; j++)
        if (((hist[j] ^ hist[0]) & mask) != 0) same = 1'b0;
      if (same) m_acc = (m_acc & ~mask) | (hist[0] & mask);
    end
  endtask

  task automatic step(input logic r, input logic [9:0] k, input logic [2:0] b);
    @(negedge clk);
    rst = r;
    io.keypad_raw = k;
    io.startn_raw = b[0];
    io.stopn_raw  = b[1];
    io.clearn_raw = b[2];
    @(posedge clk);
    cyc++;
    model_edge(r, {b, k});
    #2;
    check_val("keypad",     io.keypad,     m_keypad);
    check_val("key_code",   io.key_code,   m_code);
    check_val("key_strobe", io.key_strobe, m_strobe);
    check_val("startn",     io.startn,     m_acc[10]);
    check_val("stopn",      io.stopn,      m_acc[11]);
    check_val("clearn",     io.clearn,     m_acc[12]);
    if (io.key_strobe) begin n_strobe++; strobe_cyc = cyc; strobe_code = io.key_code; end
    if (io.startn !== last_startn) begin
      if (!io.startn) fall_cyc = cyc; else rise_cyc = cyc;
    end
    last_startn = io.startn;
    if (!io.stopn || !io.clearn) other_low++;
  endtask

  task automatic hold(input int n, input logic [9:0] k, input logic [2:0] b);
    for (int i = 0; i < n; i++) step(1'b0, k, b);
  endtask

  int mark;
  logic [9:0] rk;
  logic [2:0] rb;

  initial begin
    rst = 1'b1;
    io.keypad_raw = '0; io.startn_raw = 1'b1; io.stopn_raw = 1'b1; io.clearn_raw = 1'b1;
    for (int i = 0; i < N + 3; i++) hist.push_back(IDLE_VAL);
    m_acc = IDLE_VAL; m_mode = 0; m_keypad = '0; m_code = '0; m_strobe = 1'b0;
    last_startn = 1'b1; n_strobe = 0; strobe_cyc = 0; strobe_code = '0;
    fall_cyc = 0; rise_cyc = 0; other_low = 0;

    // reset and idle
    for (int i = 0; i < 3; i++) step(1'b1, '0, 3'b111);
    hold(6, '0, 3'b111);
    check_val("reset_no_strobe", n_strobe, 0);

    // clean press of key 5
    n_strobe = 0; mark = cyc + 1;
    hold(20, 10'b0000100000, 3'b111);
    hold(12, '0, 3'b111);
    check_val("press_strobes", n_strobe, 1);
    check_val("press_latency", strobe_cyc - mark + 1, 8);
    check_val("press_code", strobe_code, 5);

    // 3-high/2-low bounce on key 3, then stable high
    n_strobe = 0;
    for (int i = 0; i < 30; i++) step(1'b0, ((i % 5) < 3) ? 10'b0000001000 : 10'b0, 3'b111);
    check_val("bounce_no_strobe", n_strobe, 0);
    mark = cyc + 1;
    hold(15, 10'b0000001000, 3'b111);
    check_val("bounce_strobes", n_strobe, 1);
    check_val("bounce_latency", strobe_cyc - mark + 1, 8);
    check_val("bounce_code", strobe_code, 3);
    hold(12, '0, 3'b111);

    // keys 1+2 together, then key 1 alone, then release and key 7
    n_strobe = 0;
    hold(20, 10'b0000000110, 3'b111);
    check_val("multi_keypad", io.keypad, 0);
    hold(20, 10'b0000000010, 3'b111);
    check_val("lockout_strobes", n_strobe, 0);
    hold(12, '0, 3'b111);
    hold(15, 10'b0010000000, 3'b111);
    check_val("after_lock_strobes", n_strobe, 1);
    check_val("after_lock_code", strobe_code, 7);
    hold(12, '0, 3'b111);

    // start button: short pulse rejected, long press accepted
    other_low = 0; fall_cyc = 0;
    hold(4, '0, 3'b110);
    hold(12, '0, 3'b111);
    check_val("start_pulse_rejected", fall_cyc, 0);
    mark = cyc + 1;
    hold(10, '0, 3'b110);
    check_val("start_fall_latency", fall_cyc - mark + 1, 7);
    mark = cyc + 1;
    hold(12, '0, 3'b111);
    check_val("start_rise_latency", rise_cyc - mark + 1, 7);
    check_val("other_buttons_idle", other_low, 0);

    // reset while key 9 is held
    hold(15, 10'b1000000000, 3'b111);
    check_val("k9_accepted", io.keypad, 10'b1000000000);
    step(1'b1, 10'b1000000000, 3'b111);
    check_val("mid_reset_keypad", io.keypad, 0);
    check_val("mid_reset_code", io.key_code, 0);
    n_strobe = 0; mark = cyc + 1;
    hold(15, 10'b1000000000, 3'b111);
    check_val("rearm_strobes", n_strobe, 1);
    check_val("rearm_latency", strobe_cyc - mark + 1, 8);
    check_val("rearm_code", strobe_code, 9);
    hold(12, '0, 3'b111);

    // random traffic: run lengths straddle the acceptance threshold
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 3))
        0:       rk = '0;
        1, 2:    rk = 10'(1) << $urandom_range(0, 9);
        default: rk = 10'($urandom);
      endcase
      rb = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      hold($urandom_range(1, 9), rk, rb);
      if ($urandom_range(0, 30) == 0) step(1'b1, rk, rb);
    end
    hold(12, '0, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
